// File: rtl/router_sync_n.sv
// ---------------------------------------------------------------------------
// router_sync_n
//
// Synchroniser between the router FSM and NUM_CH output FIFOs.
//   * Latches the destination address decoded by the FSM.
//   * Steers a one-hot write enable to the selected FIFO.
//   * Returns the selected FIFO's full flag to the FSM.
//   * Derives per-channel vld_out from the FIFO empty flags.
//   * Runs an independent read-timeout watchdog per channel. When a FIFO
//     holds data that nobody reads, the watchdog pulses soft_reset to
//     flush it.
//
// Parameters
//   NUM_CH   number of output channels, 2..16
//   ADDR_W   width of the address field, >= $clog2(NUM_CH)
//   TIMEOUT  watchdog terminal count, 1..2**TMR_W-1
//   TMR_W    watchdog counter width
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   data_in        address field from the packet header
//   detect_add     FSM strobe: latch data_in as the destination
//   write_enb_reg  FSM write request for the current destination
//   full           per-FIFO full flags
//   empty          per-FIFO empty flags
//   read_enb       per-channel downstream read enables
//   write_enb      one-hot FIFO write enable
//   fifo_full      full flag of the selected FIFO
//   addr_valid     latched address is below NUM_CH
//   vld_out        per-channel data valid (~empty)
//   soft_reset     per-channel one-cycle FIFO flush pulse
//   status_clr     clear the sticky timeout flags (ROUTER_SYNC_STATUS_EN only)
//   to_status      sticky timeout flags (ROUTER_SYNC_STATUS_EN only)
//
// Optional feature
//   Define ROUTER_SYNC_STATUS_EN to add status_clr/to_status and the sticky
//   timeout status register. With it undefined, both ports and their logic
//   are absent.
// ---------------------------------------------------------------------------
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = $clog2(NUM_CH),
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              detect_add,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic              addr_valid,
    output logic [NUM_CH-1:0] vld_out,
`ifdef ROUTER_SYNC_STATUS_EN
    output logic [NUM_CH-1:0] soft_reset,
    input  logic              status_clr,
    output logic [NUM_CH-1:0] to_status
`else
    output logic [NUM_CH-1:0] soft_reset
`endif
);

    // NUM_CH fits in ADDR_W+1 bits because NUM_CH <= 2**ADDR_W.
    localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(NUM_CH);
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(TIMEOUT);

    // -----------------------------------------------------------------------
    // Address register
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Write steering and full-flag mux (combinational from addr_q)
    // -----------------------------------------------------------------------
    // Decoding via a per-channel compare, rather than a shift or an indexed
    // select, keeps an out-of-range address from reaching any channel.
    always_comb begin
        addr_valid = ({1'b0, addr_q} < ADDR_LIM);
        write_enb  = '0;
        fifo_full  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    // -----------------------------------------------------------------------
    // Per-channel read-timeout watchdog
    // -----------------------------------------------------------------------
    // A channel stalls when its FIFO holds data that is not being read. The
    // counter runs 0..TIMEOUT. On the stall edge that finds it at TIMEOUT,
    // it fires and wraps to 0, so a continued stall pulses every TIMEOUT+1
    // edges. Any non-stall edge clears it, including one that would fire.
    logic [NUM_CH-1:0][TMR_W-1:0] timer_q;
    logic [NUM_CH-1:0][TMR_W-1:0] timer_d;
    logic [NUM_CH-1:0]            soft_reset_q;
    logic [NUM_CH-1:0]            soft_reset_d;

    always_comb begin
        timer_d      = '0;
        soft_reset_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!empty[i] && !read_enb[i]) begin
                if (timer_q[i] == TMR_END) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    timer_d[i] = timer_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q      <= '0;
            soft_reset_q <= '0;
        end else begin
            timer_q      <= timer_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset = soft_reset_q;

`ifdef ROUTER_SYNC_STATUS_EN
    // -----------------------------------------------------------------------
    // Sticky timeout status
    // -----------------------------------------------------------------------
    // The flag sets on the same edge that registers the soft_reset pulse. A
    // new timeout wins over a coincident clear.
    logic [NUM_CH-1:0] to_status_q;
    logic [NUM_CH-1:0] to_status_d;

    always_comb begin
        to_status_d = to_status_q;
        if (status_clr) begin
            to_status_d = '0;
        end
        to_status_d = to_status_d | soft_reset_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_status_q <= '0;
        end else begin
            to_status_q <= to_status_d;
        end
    end

    assign to_status = to_status_q;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// ---------------------------------------------------------------------------
// tb_router_sync_n
//
// Directed testbench for router_sync_n with NUM_CH=3 and TIMEOUT=30.
// Expected values are hand-derived. Inputs change 1 ns after a rising edge,
// and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_router_sync_n;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] data_in;
    logic       detect_add;
    logic       write_enb_reg;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       addr_valid;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
`ifdef ROUTER_SYNC_STATUS_EN
    logic       status_clr;
    logic [2:0] to_status;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    router_sync_n #(
        .NUM_CH (3),
        .ADDR_W (2),
        .TIMEOUT(30),
        .TMR_W  (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .detect_add   (detect_add),
        .write_enb_reg(write_enb_reg),
        .full         (full),
        .empty        (empty),
        .read_enb     (read_enb),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .addr_valid   (addr_valid),
        .vld_out      (vld_out),
`ifdef ROUTER_SYNC_STATUS_EN
        .soft_reset   (soft_reset),
        .status_clr   (status_clr),
        .to_status    (to_status)
`else
        .soft_reset   (soft_reset)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drain every channel for one edge so all timers restart from 0.
    task automatic idle_edge();
        empty    = 3'b111;
        read_enb = 3'b000;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        data_in       = '0;
        detect_add    = 1'b0;
        write_enb_reg = 1'b0;
        full          = 3'b000;
        empty         = 3'b111;
        read_enb      = 3'b000;
`ifdef ROUTER_SYNC_STATUS_EN
        status_clr    = 1'b0;
`endif
        step();
        step();

        // ---- reset state
        check("rst_soft_reset", 32'(soft_reset), 32'h0);
        check("rst_write_enb", 32'(write_enb), 32'h0);
        check("rst_addr_valid", 32'(addr_valid), 32'h1);
        check("rst_vld_out", 32'(vld_out), 32'h0);
        check("rst_fifo_full", 32'(fifo_full), 32'h0);
`ifdef ROUTER_SYNC_STATUS_EN
        check("rst_to_status", 32'(to_status), 32'h0);
`endif
        reset = 1'b0;
        step();

        // ---- vld_out follows ~empty combinationally
        empty = 3'b010;
        #1;
        check("vld_out_101", 32'(vld_out), 32'h5);
        empty = 3'b111;

        // ---- latch address 2; write_enb uses the old address (0) until the edge
        detect_add    = 1'b1;
        data_in       = 2'd2;
        write_enb_reg = 1'b1;
        #1;
        check("wen_old_addr", 32'(write_enb), 32'h1);
        step();
        detect_add = 1'b0;
        data_in    = 2'd0;
        #1;
        check("wen_addr2", 32'(write_enb), 32'h4);
        full = 3'b100;
        #1;
        check("ffull_addr2_set", 32'(fifo_full), 32'h1);
        full = 3'b011;
        #1;
        check("ffull_addr2_clr", 32'(fifo_full), 32'h0);
        write_enb_reg = 1'b0;
        #1;
        check("wen_no_req", 32'(write_enb), 32'h0);

        // ---- out-of-range address 3
        detect_add = 1'b1;
        data_in    = 2'd3;
        step();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b111;
        #1;
        check("addr3_valid", 32'(addr_valid), 32'h0);
        check("addr3_wen", 32'(write_enb), 32'h0);
        check("addr3_ffull", 32'(fifo_full), 32'h0);

        // ---- address 1
        detect_add = 1'b1;
        data_in    = 2'd1;
        step();
        detect_add = 1'b0;
        full       = 3'b010;
        #1;
        check("addr1_valid", 32'(addr_valid), 32'h1);
        check("addr1_wen", 32'(write_enb), 32'h2);
        check("addr1_ffull", 32'(fifo_full), 32'h1);
        write_enb_reg = 1'b0;
        full          = 3'b000;

        // ---- channel 0 stall: pulses after edge 31 and edge 62
        idle_edge();
        empty = 3'b110;
        for (int e = 1; e <= 62; e++) begin
            step();
            check($sformatf("wd0_e%0d", e), 32'(soft_reset), (e == 31 || e == 62) ? 32'h1 : 32'h0);
        end

        // ---- channel 0 stall with a read at edge 30: pulse at edge 61
        idle_edge();
        empty = 3'b110;
        for (int e = 1; e <= 62; e++) begin
            read_enb = (e == 30) ? 3'b001 : 3'b000;
            step();
            check($sformatf("wd0rd_e%0d", e), 32'(soft_reset), (e == 61) ? 32'h1 : 32'h0);
        end
        read_enb = 3'b000;

        // ---- channels 1 and 2 stalled together, channel 0 idle
        idle_edge();
        empty = 3'b001;
        for (int e = 1; e <= 32; e++) begin
            step();
            check($sformatf("wd12_e%0d", e), 32'(soft_reset), (e == 31) ? 32'h6 : 32'h0);
        end

        // ---- async reset with a pulse pending clears it immediately
        idle_edge();
        empty = 3'b110;
        for (int e = 1; e <= 31; e++) step();
        check("pulse_before_rst", 32'(soft_reset), 32'h1);
        reset = 1'b1;
        #1;
        check("pulse_async_clr", 32'(soft_reset), 32'h0);
        reset = 1'b0;
        #2;

        // ---- async reset mid-count (timer=15) restarts the count from 0
        idle_edge();
        empty = 3'b110;
        for (int e = 1; e <= 15; e++) step();
        reset = 1'b1;
        #2;
        write_enb_reg = 1'b1;
        #1;
        check("midrst_addr_zero", 32'(write_enb), 32'h1);
        write_enb_reg = 1'b0;
        reset = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            step();
            check($sformatf("midrst_e%0d", e), 32'(soft_reset), (e == 31) ? 32'h1 : 32'h0);
        end

`ifdef ROUTER_SYNC_STATUS_EN
        // ---- sticky status on channel 1
        idle_edge();
        check("sts_clean", 32'(to_status), 32'h0);
        empty = 3'b101;
        for (int e = 1; e <= 30; e++) step();
        check("sts_before", 32'(to_status), 32'h0);
        step();
        check("sts_set_pulse", 32'(soft_reset), 32'h2);
        check("sts_set", 32'(to_status), 32'h2);
        idle_edge();
        step();
        check("sts_hold", 32'(to_status), 32'h2);
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        check("sts_cleared", 32'(to_status), 32'h0);

        // ---- set and clear on the same edge: set wins
        empty = 3'b101;
        for (int e = 1; e <= 30; e++) step();
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        check("sts_set_wins", 32'(to_status), 32'h2);
        idle_edge();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised synchroniser for the N-output router: latches the destination address decoded by the FSM, steers the write-enable one-hot to the selected output FIFO, and muxes that FIFO's full flag back to the FSM. It derives per-channel `vld_out` from FIFO empty flags and runs an independent read-timeout watchdog per channel that pulses `soft_reset` to flush an unread FIFO. Sits between the router FSM and the NUM_CH output FIFOs. It generalises the fixed 3-channel synchroniser with configurable channel count and timeout, an address-valid flag and optional sticky timeout status.

## Interface
- `NUM_CH`, 3: number of output channels/FIFOs, 2..16.
- `ADDR_W`, `$clog2(NUM_CH)`: address field width taken from `data_in`; must be ≥ `$clog2(NUM_CH)`.
- `TIMEOUT`, 30: watchdog terminal count, 1..2^TMR_W−1.
- `TMR_W`, 5: watchdog counter width.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data_in` in ADDR_W: address byte field from the packet header.
- `detect_add` in 1: FSM strobe; latch `data_in` as destination.
- `write_enb_reg` in 1: FSM write request for the current destination.
- `full` in NUM_CH: per-FIFO full flags.
- `empty` in NUM_CH: per-FIFO empty flags.
- `read_enb` in NUM_CH: per-channel downstream read enables.
- `write_enb` out NUM_CH: one-hot FIFO write enable.
- `fifo_full` out 1: full flag of the selected FIFO.
- `addr_valid` out 1: latched address < NUM_CH.
- `vld_out` out NUM_CH: per-channel data valid.
- `soft_reset` out NUM_CH: per-channel FIFO flush pulse.
- `status_clr` in 1: clear sticky status (only with ROUTER_SYNC_STATUS_EN).
- `to_status` out NUM_CH: sticky timeout flags (only with ROUTER_SYNC_STATUS_EN).

## Operation
- Address register `addr_q` (ADDR_W): reset 0; on each edge with `detect_add`=1 loads `data_in`; otherwise holds.
- `addr_valid` = (`addr_q` < NUM_CH), combinational from `addr_q`.
- `write_enb` = `write_enb_reg` && `addr_valid` ? (1 << `addr_q`) : 0. Never more than one bit set.
- `fifo_full` = `addr_valid` ? `full[addr_q]` : 0.
- `vld_out[i]` = ~`empty[i]`, combinational.
- Watchdog per channel i: `stall_i` = `vld_out[i]` && !`read_enb[i]`. On each edge:
  - !`stall_i`: `timer_i` ← 0, `soft_reset[i]` ← 0.
  - `stall_i` and `timer_i` == TIMEOUT: `timer_i` ← 0, `soft_reset[i]` ← 1.
  - `stall_i` otherwise: `timer_i` ← `timer_i`+1, `soft_reset[i]` ← 0.
- Channels are fully independent; any number may time out on the same edge.
- A continued stall after a pulse restarts the count from 0; the next pulse follows TIMEOUT+1 edges later.

## Timing
- Reset (async assert, sync-free release): `addr_q`=0, all `timer_i`=0, `soft_reset`=0, `to_status`=0. Combinational outputs follow their inputs, e.g. `write_enb`=0 while `write_enb_reg`=0.
- `addr_q` latency: 1 cycle. If `detect_add` and `write_enb_reg` are both high in the same cycle, `write_enb`/`fifo_full` use the old `addr_q`.
- `write_enb`, `fifo_full`, `vld_out`, `addr_valid`: 0-cycle combinational paths.
- `soft_reset[i]`: registered, high for exactly one cycle. It rises on the (TIMEOUT+1)th consecutive stall edge counted from `timer_i`=0.
- A read (`read_enb[i]`=1) or an empty FIFO on any edge clears `timer_i`, including the edge that would have fired.
- Reset asserted mid-count clears the timer and any pending pulse immediately.

## Configuration
- `ROUTER_SYNC_STATUS_EN` defined: adds `status_clr` and `to_status`.
  - `to_status[i]` is set on the edge where `soft_reset[i]` is registered high.
  - `status_clr`=1 clears all bits on the next edge.
  - When set and clear coincide, set wins.
- `ROUTER_SYNC_STATUS_EN` undefined: both ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset, `detect_add`=1 with `data_in`=2, then `write_enb_reg`=1 → `write_enb`=3'b100 one cycle after the latch; `full`=3'b100 → `fifo_full`=1.
- NUM_CH=3, `data_in`=3 latched → `addr_valid`=0, `write_enb`=0 with `write_enb_reg`=1, `fifo_full`=0 with `full`=3'b111.
- `empty[0]`=0, `read_enb[0]`=0 held from `timer_0`=0 → `soft_reset[0]`=1 after edge 31 (TIMEOUT=30) for exactly one cycle; next pulse after edge 62.
- Same stall with `read_enb[0]` pulsed at edge 30 → no `soft_reset[0]`; the pulse arrives 31 edges after the read.
- Channels 1 and 2 stalled simultaneously → both `soft_reset` bits pulse on the same edge; channel 0 unaffected.
- With ROUTER_SYNC_STATUS_EN: a timeout sets `to_status[1]`, which holds until `status_clr`; `status_clr` coinciding with a new pulse leaves the bit set. Async `reset` mid-count (timer=15) → timer 0, no pulse.
